// File: rtl/param_register_file_if.sv
// Decode/writeback bus of the parametrised register file: read ports, write port,
// issue marking and flush. Widths must match the attached param_register_file.
interface param_register_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     iss_en;
  logic [ADDR_W-1:0]        iss_addr;
  logic                     flush;

  // No valid/ready pair: the write and issue ports always accept in the cycle
  // they are asserted, and decode is expected to stall itself on rd_busy.
  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    input  rd_data, rd_busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    output rd_data, rd_busy
  );
endinterface

// File: rtl/param_register_file.sv
// Multi-read-port register file with write-through bypass, optional hardwired
// zero register and a per-register pending-write scoreboard for RAW stalls.
module param_register_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  param_register_file_if.slave rf
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0]        mem [DEPTH];
  logic [DEPTH-1:0]         busy;
  logic [DEPTH-1:0]         busyNext;
  logic                     wrEn;
  logic                     memWrite;
  logic [NUM_RD*DATA_W-1:0] rdDataC;
  logic [NUM_RD-1:0]        rdBusyC;
  logic [ADDR_W-1:0]        portAddr;
  logic                     portZero;
  logic                     portByp;

  assign wrEn     = (rf.wr_en == 1'b1);
  assign memWrite = wrEn && !((ZERO_REG != 0) && (rf.wr_addr == '0));

  // Issue is applied after the writeback clear so the newer producer wins.
  always_comb begin
    busyNext = busy;
    if (rf.flush) begin
      busyNext = '0;
    end else begin
      if (wrEn)
        busyNext[rf.wr_addr] = 1'b0;
      if (rf.iss_en && !((ZERO_REG != 0) && (rf.iss_addr == '0)))
        busyNext[rf.iss_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++)
        mem[r] <= '0;
      busy <= '0;
    end else begin
      if (memWrite)
        mem[rf.wr_addr] <= rf.wr_data;
      busy <= busyNext;
    end
  end

  // A same-cycle writeback both forwards its data and hides the busy bit.
  always_comb begin
    rdDataC  = '0;
    rdBusyC  = '0;
    portAddr = '0;
    portZero = 1'b0;
    portByp  = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      portAddr = rf.rd_addr[i*ADDR_W +: ADDR_W];
      portZero = (ZERO_REG != 0) && (portAddr == '0);
      portByp  = wrEn && (rf.wr_addr == portAddr);
      if (portZero)
        rdDataC[i*DATA_W +: DATA_W] = '0;
      else if (portByp)
        rdDataC[i*DATA_W +: DATA_W] = rf.wr_data;
      else
        rdDataC[i*DATA_W +: DATA_W] = mem[portAddr];
      rdBusyC[i] = !portZero && !portByp && busy[portAddr];
    end
  end

  assign rf.rd_data = rdDataC;
  assign rf.rd_busy = rdBusyC;
endmodule

// File: doc/param_register_file.md
# param_register_file

Parametrised multi-read-port general-purpose register file for the 32-bit MIPS datapath, replacing the fixed 2-read/1-write `register_file`. It adds a clocked write port with same-cycle write-through bypass, a configurable hardwired-zero register, asynchronous clearing of all registers, and a per-register pending-write scoreboard. The scoreboard lets decode stall on RAW hazards against in-flight producers. It sits between decode (reads, issue) and writeback (write).

## Interface
- DATA_W, 32, register width in bits (≥1)
- ADDR_W, 5, address width; depth = 2**ADDR_W (1..6)
- NUM_RD, 2, number of independent read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never busy; 0 = register 0 is ordinary
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  1 = port i's register has an outstanding producer
- wr_en  in  1  writeback write enable (X treated as no write by bench; RTL uses ==1'b1)
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- iss_en  in  1  issue: mark iss_addr as pending a write
- iss_addr  in  ADDR_W  destination of issued instruction
- flush  in  1  synchronous clear of all busy bits (pipeline flush)

## Operation
- Storage: 2**ADDR_W x DATA_W flops plus 2**ADDR_W busy bits.
- Write: on rising clk, if wr_en=1, mem[wr_addr] <= wr_data; suppressed when ZERO_REG=1 and wr_addr=0.
- Read (combinational, per port i):
  - If ZERO_REG=1 and rd_addr_i=0 → 0.
  - Else if wr_en=1 and wr_addr=rd_addr_i → wr_data (write-through bypass).
  - Else mem[rd_addr_i].
- Multiple ports may read the same address; each is independent.
- Scoreboard per register r, next state at rising clk, in priority order:
  - flush=1 → all busy <= 0 (also overrides same-cycle iss_en).
  - iss_en=1 and iss_addr=r → busy[r] <= 1 (set wins over a same-cycle write to r: the newer producer).
  - wr_en=1 and wr_addr=r → busy[r] <= 0.
  - Otherwise hold.
  - Register 0 is never set when ZERO_REG=1.
- rd_busy_i = busy[rd_addr_i] & ~(wr_en & wr_addr==rd_addr_i), forced 0 for reg 0 when ZERO_REG=1. A same-cycle writeback therefore hides busy, consistent with the bypass.
- Writes to a non-busy register are legal; busy stays 0.

## Timing
- Reset (rst_n=0, asynchronous, immediate): all mem <= 0, all busy <= 0. While reset is held, rd_data = 0 and rd_busy = 0, except that a bypass still forwards wr_data combinationally (bench keeps wr_en=0 during reset).
- Reset deassertion mid-operation: the first edge after rst_n rises performs a normal update. In-flight issue/write state is lost by design.
- Write latency: data is visible on read ports in the same cycle via bypass, and from mem the cycle after the edge.
- Issue latency: rd_busy rises the cycle after the iss_en edge. Clear is visible combinationally in the writeback cycle.
- No handshake: the write port always accepts. Decode must stall on rd_busy itself.
- All read paths are purely combinational from rd_addr/wr_* to rd_data/rd_busy. There are no combinational loops.

## Test plan
- Reset: assert rst_n=0 mid-run after writing r4=0x12345678 → rd_data=0 on all ports immediately. After release, r4 reads 0.
- Write disabled: wr_en=0, wr_addr=4, wr_data=0x00000112, one edge → r4 still 0. ZERO_REG=1, wr_en=1, wr_addr=0, wr_data=0x00000112 → r0 reads 0 and rd_busy=0.
- Write/readback: wr_en=1, wr_addr=16, wr_data=0x80000000 → port0 with rd_addr=16 shows 0x80000000 in the same cycle (bypass) and after the edge with wr_en=0. Port1 on r7 is unaffected (0).
- Scoreboard: iss_en=1, iss_addr=9, then rd_addr=9 → rd_busy=1 next cycle. Writeback wr_addr=9, wr_data=0xDEADBEEF → same cycle rd_busy=0 and rd_data=0xDEADBEEF; busy stays 0 after the edge.
- Simultaneous: same cycle iss_en r9 and wr_en r9 → busy[9]=1 after the edge. Then flush=1 together with iss_en r3 → all busy 0, including r3.
- Params: NUM_RD=4, DATA_W=16, ADDR_W=3, ZERO_REG=0 → write r0=0xA5A5, all four ports on r0 read 0xA5A5. Write to r7 then read r7 shows correct data; no aliasing into r0.
